// File: rtl/axi_lite_pkg.sv
// -----------------------------------------------------------------------------
// axi_lite_pkg
// Shared constants and FSM state types for the AXI4-Lite memory slave.
//   RESP_OKAY / RESP_SLVERR : response codes driven on bresp / rresp
//   wr_state_t              : write channel FSM states
//   rd_state_t              : read channel FSM states
// -----------------------------------------------------------------------------
package axi_lite_pkg;

  localparam logic [2:0] RESP_OKAY   = 3'b000;
  localparam logic [2:0] RESP_SLVERR = 3'b010;

  typedef enum logic {
    W_IDLE = 1'b0,
    W_RESP = 1'b1
  } wr_state_t;

  typedef enum logic {
    R_IDLE = 1'b0,
    R_DATA = 1'b1
  } rd_state_t;

endpackage

// File: rtl/axi_lite_regfile.sv
// -----------------------------------------------------------------------------
// axi_lite_regfile
// Word-organised storage behind the AXI4-Lite slave.
//   clk, rst_n : clock and asynchronous active-low clear (all words -> 0)
//   wr_en      : write strobe, wr_idx selects the word
//   wr_data    : write data, wr_be enables individual bytes
//   rd_en      : registered read; rd_data updates on the edge after rd_en
//   rd_data    : read data, held until the next rd_en
// -----------------------------------------------------------------------------
module axi_lite_regfile #(
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH      = 8,
  parameter int IDX_WIDTH  = 3
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    wr_en,
  input  logic [IDX_WIDTH-1:0]    wr_idx,
  input  logic [DATA_WIDTH-1:0]   wr_data,
  input  logic [DATA_WIDTH/8-1:0] wr_be,
  input  logic                    rd_en,
  input  logic [IDX_WIDTH-1:0]    rd_idx,
  output logic [DATA_WIDTH-1:0]   rd_data
);

  localparam int NBYTES = DATA_WIDTH / 8;

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  // Storage array with byte-granular writes. The caller guarantees wr_idx is
  // below DEPTH, so no range check is repeated here.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else if (wr_en) begin
      for (int b = 0; b < NBYTES; b++) begin
        if (wr_be[b]) begin
          mem[wr_idx][b*8 +: 8] <= wr_data[b*8 +: 8];
        end
      end
    end
  end

  // Registered read port. Because the array update is non-blocking, a read
  // and a write of the same word on one edge returns the old contents.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_data <= '0;
    end else if (rd_en) begin
      rd_data <= mem[rd_idx];
    end
  end

endmodule

// File: rtl/axi_lite_mem_slave.sv
// -----------------------------------------------------------------------------
// axi_lite_mem_slave
// AXI4-Lite slave exposing DEPTH words of DATA_WIDTH-bit memory.
//   s0_axi_aclk / s0_axi_aresetn : clock, asynchronous active-low reset
//   AW, W, B channels             : write address, data (+wstrb), response
//   AR, R channels                : read address, read data + response
// Word index is addr[ADDR_WIDTH-1:2]; indices >= DEPTH answer SLVERR.
// Build option AXI_MEM_WSTRB_EN: when defined, wstrb selects individual
// bytes; when undefined, any nonzero wstrb writes the whole word.
// -----------------------------------------------------------------------------
module axi_lite_mem_slave
  import axi_lite_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 8,
  parameter int RESP_WIDTH = 3,
  parameter int DEPTH      = 8
) (
  input  logic                    s0_axi_aclk,
  input  logic                    s0_axi_aresetn,
  input  logic [ADDR_WIDTH-1:0]   s0_axi_awaddr,
  input  logic                    s0_axi_awvalid,
  output logic                    s0_axi_awready,
  input  logic [DATA_WIDTH-1:0]   s0_axi_wdata,
  input  logic [DATA_WIDTH/8-1:0] s0_axi_wstrb,
  input  logic                    s0_axi_wvalid,
  output logic                    s0_axi_wready,
  output logic [RESP_WIDTH-1:0]   s0_axi_bresp,
  output logic                    s0_axi_bvalid,
  input  logic                    s0_axi_bready,
  input  logic [ADDR_WIDTH-1:0]   s0_axi_araddr,
  input  logic                    s0_axi_arvalid,
  output logic                    s0_axi_arready,
  output logic [DATA_WIDTH-1:0]   s0_axi_rdata,
  output logic [RESP_WIDTH-1:0]   s0_axi_rresp,
  output logic                    s0_axi_rvalid,
  input  logic                    s0_axi_rready
);

  localparam int          STRB_WIDTH = DATA_WIDTH / 8;
  localparam int          WIDX_WIDTH = ADDR_WIDTH - 2;
  localparam int          IDX_WIDTH  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [31:0] DEPTH_U    = 32'(DEPTH);

  wr_state_t w_state, w_state_next;
  rd_state_t r_state, r_state_next;

  logic                  ready_en;
  logic                  aw_lat, w_lat;
  logic [WIDX_WIDTH-1:0] aw_idx_q;
  logic [DATA_WIDTH-1:0] w_data_q;
  logic [STRB_WIDTH-1:0] w_strb_q;
  logic [RESP_WIDTH-1:0] bresp_q, rresp_q;
  logic                  rd_err_q;

  logic                  aw_hs, w_hs, ar_hs, wr_fire;
  logic [WIDX_WIDTH-1:0] wr_word_idx, rd_word_idx;
  logic [DATA_WIDTH-1:0] wr_data;
  logic [STRB_WIDTH-1:0] wr_strb, wr_be;
  logic                  wr_in_range, rd_in_range;
  logic [DATA_WIDTH-1:0] rf_rdata;
  logic                  addr_lsbs_unused;

  // Byte offset bits carry no meaning for word-wide accesses.
  assign addr_lsbs_unused = ^{s0_axi_awaddr[1:0], s0_axi_araddr[1:0]};

  assign aw_hs = s0_axi_awvalid && s0_axi_awready;
  assign w_hs  = s0_axi_wvalid  && s0_axi_wready;
  assign ar_hs = s0_axi_arvalid && s0_axi_arready;

  // The write goes ahead on the edge where the second of AW/W arrives, so
  // take each field from its latch if it came earlier, else from the bus.
  assign wr_fire     = (w_state == W_IDLE) && (aw_lat || aw_hs) && (w_lat || w_hs);
  assign wr_word_idx = aw_lat ? aw_idx_q : s0_axi_awaddr[ADDR_WIDTH-1:2];
  assign wr_data     = w_lat  ? w_data_q : s0_axi_wdata;
  assign wr_strb     = w_lat  ? w_strb_q : s0_axi_wstrb;
  assign wr_in_range = 32'(wr_word_idx) < DEPTH_U;

  assign rd_word_idx = s0_axi_araddr[ADDR_WIDTH-1:2];
  assign rd_in_range = 32'(rd_word_idx) < DEPTH_U;

`ifdef AXI_MEM_WSTRB_EN
  assign wr_be = wr_strb;
`else
  assign wr_be = {STRB_WIDTH{|wr_strb}};
`endif

  // State register for both channel FSMs.
  always_ff @(posedge s0_axi_aclk or negedge s0_axi_aresetn) begin
    if (!s0_axi_aresetn) begin
      w_state <= W_IDLE;
      r_state <= R_IDLE;
    end else begin
      w_state <= w_state_next;
      r_state <= r_state_next;
    end
  end

  // Next-state logic: write waits for both halves then for bready, read
  // waits for the address then for rready.
  always_comb begin
    w_state_next = w_state;
    r_state_next = r_state;
    case (w_state)
      W_IDLE:  if (wr_fire)       w_state_next = W_RESP;
      W_RESP:  if (s0_axi_bready) w_state_next = W_IDLE;
      default: w_state_next = W_IDLE;
    endcase
    case (r_state)
      R_IDLE:  if (ar_hs)         r_state_next = R_DATA;
      R_DATA:  if (s0_axi_rready) r_state_next = R_IDLE;
      default: r_state_next = R_IDLE;
    endcase
  end

  // Handshake outputs. ready_en keeps the readies low while in reset and
  // lets them rise on the first edge after release.
  always_comb begin
    s0_axi_awready = ready_en && (w_state == W_IDLE) && !aw_lat;
    s0_axi_wready  = ready_en && (w_state == W_IDLE) && !w_lat;
    s0_axi_bvalid  = (w_state == W_RESP);
    s0_axi_arready = ready_en && (r_state == R_IDLE);
    s0_axi_rvalid  = (r_state == R_DATA);
  end

  // AW/W latches and write response. Each half is latched independently;
  // both are cleared on the edge the write is performed.
  always_ff @(posedge s0_axi_aclk or negedge s0_axi_aresetn) begin
    if (!s0_axi_aresetn) begin
      ready_en <= 1'b0;
      aw_lat   <= 1'b0;
      w_lat    <= 1'b0;
      aw_idx_q <= '0;
      w_data_q <= '0;
      w_strb_q <= '0;
      bresp_q  <= '0;
    end else begin
      ready_en <= 1'b1;
      if (wr_fire) begin
        aw_lat  <= 1'b0;
        w_lat   <= 1'b0;
        bresp_q <= wr_in_range ? RESP_WIDTH'(RESP_OKAY) : RESP_WIDTH'(RESP_SLVERR);
      end else begin
        if (aw_hs) begin
          aw_lat   <= 1'b1;
          aw_idx_q <= s0_axi_awaddr[ADDR_WIDTH-1:2];
        end
        if (w_hs) begin
          w_lat    <= 1'b1;
          w_data_q <= s0_axi_wdata;
          w_strb_q <= s0_axi_wstrb;
        end
      end
    end
  end

  // Read response. Out-of-range reads skip the array and force rdata to 0
  // through rd_err_q, which stays put until the next address is accepted.
  always_ff @(posedge s0_axi_aclk or negedge s0_axi_aresetn) begin
    if (!s0_axi_aresetn) begin
      rresp_q  <= '0;
      rd_err_q <= 1'b0;
    end else if (ar_hs) begin
      rresp_q  <= rd_in_range ? RESP_WIDTH'(RESP_OKAY) : RESP_WIDTH'(RESP_SLVERR);
      rd_err_q <= !rd_in_range;
    end
  end

  assign s0_axi_bresp = bresp_q;
  assign s0_axi_rresp = rresp_q;
  assign s0_axi_rdata = rd_err_q ? '0 : rf_rdata;

  axi_lite_regfile #(
    .DATA_WIDTH (DATA_WIDTH),
    .DEPTH      (DEPTH),
    .IDX_WIDTH  (IDX_WIDTH)
  ) u_regfile (
    .clk     (s0_axi_aclk),
    .rst_n   (s0_axi_aresetn),
    .wr_en   (wr_fire && wr_in_range),
    .wr_idx  (wr_word_idx[IDX_WIDTH-1:0]),
    .wr_data (wr_data),
    .wr_be   (wr_be),
    .rd_en   (ar_hs && rd_in_range),
    .rd_idx  (rd_word_idx[IDX_WIDTH-1:0]),
    .rd_data (rf_rdata)
  );

endmodule

// File: tb/tb_axi_lite_mem_slave.sv
// -----------------------------------------------------------------------------
// tb_axi_lite_mem_slave
// Self-checking bench for axi_lite_mem_slave. A word-array reference model
// tracks expected memory contents; directed scenarios cover the timing rules
// and a randomized loop covers general traffic. Honours AXI_MEM_WSTRB_EN.
// -----------------------------------------------------------------------------
module tb_axi_lite_mem_slave;

  localparam int DEPTH = 8;

  logic        clk   = 1'b0;
  logic        rst_n = 1'b1;
  logic [7:0]  awaddr = '0;
  logic        awvalid = 1'b0;
  logic        awready;
  logic [31:0] wdata = '0;
  logic [3:0]  wstrb = '0;
  logic        wvalid = 1'b0;
  logic        wready;
  logic [2:0]  bresp;
  logic        bvalid;
  logic        bready = 1'b0;
  logic [7:0]  araddr = '0;
  logic        arvalid = 1'b0;
  logic        arready;
  logic [31:0] rdata;
  logic [2:0]  rresp;
  logic        rvalid;
  logic        rready = 1'b0;

  int tests_run = 0;
  int tests_failed = 0;

  logic [31:0] model_mem [DEPTH];

  always #5 clk = ~clk;

  axi_lite_mem_slave dut (
    .s0_axi_aclk    (clk),
    .s0_axi_aresetn (rst_n),
    .s0_axi_awaddr  (awaddr),
    .s0_axi_awvalid (awvalid),
    .s0_axi_awready (awready),
    .s0_axi_wdata   (wdata),
    .s0_axi_wstrb   (wstrb),
    .s0_axi_wvalid  (wvalid),
    .s0_axi_wready  (wready),
    .s0_axi_bresp   (bresp),
    .s0_axi_bvalid  (bvalid),
    .s0_axi_bready  (bready),
    .s0_axi_araddr  (araddr),
    .s0_axi_arvalid (arvalid),
    .s0_axi_arready (arready),
    .s0_axi_rdata   (rdata),
    .s0_axi_rresp   (rresp),
    .s0_axi_rvalid  (rvalid),
    .s0_axi_rready  (rready)
  );

  // Reference model: word index from address bits [7:2], SLVERR beyond DEPTH.
  function automatic logic [2:0] model_resp(input logic [7:0] a);
    return (int'(a[7:2]) >= DEPTH) ? 3'b010 : 3'b000;
  endfunction

  function automatic logic [31:0] model_read(input logic [7:0] a);
    if (int'(a[7:2]) >= DEPTH) return 32'h0;
    return model_mem[int'(a[7:2])];
  endfunction

  function automatic void model_write(input logic [7:0] a, input logic [31:0] d,
                                      input logic [3:0] s);
    int idx;
    idx = int'(a[7:2]);
    if (idx >= DEPTH) return;
`ifdef AXI_MEM_WSTRB_EN
    for (int b = 0; b < 4; b++) begin
      if (s[b]) model_mem[idx][b*8 +: 8] = d[b*8 +: 8];
    end
`else
    if (s != 4'h0) model_mem[idx] = d;
`endif
  endfunction

  // Write transaction driver; AW/W can each be delayed by some cycles.
  task automatic do_write(input logic [7:0] a, input logic [31:0] d, input logic [3:0] s,
                          input int aw_dly, input int w_dly,
                          output logic [2:0] resp, output bit ok);
    bit aw_done;
    bit w_done;
    aw_done = 1'b0;
    w_done  = 1'b0;
    awaddr = a; wdata = d; wstrb = s; bready = 1'b1;
    ok = 1'b0; resp = '0;
    for (int i = 0; i < 60; i++) begin
      bit aw_fire, w_fire, b_fire;
      awvalid = !aw_done && (i >= aw_dly);
      wvalid  = !w_done && (i >= w_dly);
      aw_fire = awvalid && awready;
      w_fire  = wvalid && wready;
      b_fire  = bvalid && bready;
      if (b_fire) resp = bresp;
      @(posedge clk); #1;
      if (aw_fire) aw_done = 1'b1;
      if (w_fire) w_done = 1'b1;
      if (b_fire) begin
        ok = 1'b1;
        break;
      end
    end
    awvalid = 1'b0; wvalid = 1'b0; bready = 1'b0;
  endtask

  // Read transaction driver.
  task automatic do_read(input logic [7:0] a, output logic [31:0] d,
                         output logic [2:0] resp, output bit ok);
    araddr = a; arvalid = 1'b1; rready = 1'b1;
    ok = 1'b0; d = '0; resp = '0;
    for (int i = 0; i < 60; i++) begin
      bit ar_fire, r_fire;
      ar_fire = arvalid && arready;
      r_fire  = rvalid && rready;
      if (r_fire) begin
        d = rdata;
        resp = rresp;
      end
      @(posedge clk); #1;
      if (ar_fire) arvalid = 1'b0;
      if (r_fire) begin
        ok = 1'b1;
        break;
      end
    end
    arvalid = 1'b0; rready = 1'b0;
  endtask

  // Reset values, asynchronous entry, and readies on first edge after release.
  task automatic test_reset();
    for (int i = 0; i < DEPTH; i++) model_mem[i] = '0;
    #1 rst_n = 1'b0;
    #1;
    tests_run++;
    if ({awready, wready, arready, bvalid, rvalid} !== 5'b0) begin
      tests_failed++;
      $display("[TB] FAIL reset_handshakes: got %b want 00000",
               {awready, wready, arready, bvalid, rvalid});
    end
    tests_run++;
    if ({bresp, rresp, rdata} !== 38'h0) begin
      tests_failed++;
      $display("[TB] FAIL reset_data: got bresp=%0h rresp=%0h rdata=%0h want 0", bresp, rresp, rdata);
    end
    repeat (2) @(posedge clk);
    #3 rst_n = 1'b1;
    tests_run++;
    if ({awready, wready, arready} !== 3'b000) begin
      tests_failed++;
      $display("[TB] FAIL release_before_edge: got %b want 000", {awready, wready, arready});
    end
    @(posedge clk); #1;
    tests_run++;
    if ({awready, wready, arready} !== 3'b111) begin
      tests_failed++;
      $display("[TB] FAIL release_first_edge: got %b want 111", {awready, wready, arready});
    end
  endtask

  // AW and W presented together to address 0.
  task automatic test_same_cycle();
    logic [31:0] d;
    logic [2:0]  r;
    bit ok;
    awaddr = 8'h00; wdata = 32'd56; wstrb = 4'hF;
    awvalid = 1'b1; wvalid = 1'b1; bready = 1'b1;
    tests_run++;
    if ({awready, wready} !== 2'b11) begin
      tests_failed++;
      $display("[TB] FAIL same_cycle_ready: got %b want 11", {awready, wready});
    end
    @(posedge clk); #1;
    awvalid = 1'b0; wvalid = 1'b0;
    tests_run++;
    if (bvalid !== 1'b1 || bresp !== 3'b000) begin
      tests_failed++;
      $display("[TB] FAIL same_cycle_b: got bvalid=%b bresp=%0h want 1/0", bvalid, bresp);
    end
    @(posedge clk); #1;
    bready = 1'b0;
    tests_run++;
    if (bvalid !== 1'b0 || {awready, wready} !== 2'b11) begin
      tests_failed++;
      $display("[TB] FAIL same_cycle_done: got bvalid=%b rdy=%b want 0/11", bvalid, {awready, wready});
    end
    model_write(8'h00, 32'd56, 4'hF);
    do_read(8'h00, d, r, ok);
    tests_run++;
    if (!ok || d !== 32'd56 || r !== 3'b000) begin
      tests_failed++;
      $display("[TB] FAIL same_cycle_read: got ok=%b data=%0h resp=%0h want 38/0", ok, d, r);
    end
  endtask

  // W handshake three cycles ahead of AW.
  task automatic test_w_before_aw();
    logic [31:0] d;
    logic [2:0]  r;
    bit ok;
    wdata = 32'h1234; wstrb = 4'hF; wvalid = 1'b1; bready = 1'b0;
    @(posedge clk); #1;
    wvalid = 1'b0;
    tests_run++;
    if (wready !== 1'b0 || awready !== 1'b1) begin
      tests_failed++;
      $display("[TB] FAIL w_first_ready: got wready=%b awready=%b want 0/1", wready, awready);
    end
    repeat (2) begin
      @(posedge clk); #1;
      tests_run++;
      if (bvalid !== 1'b0 || wready !== 1'b0) begin
        tests_failed++;
        $display("[TB] FAIL w_first_wait: got bvalid=%b wready=%b want 0/0", bvalid, wready);
      end
    end
    awaddr = 8'h04; awvalid = 1'b1;
    @(posedge clk); #1;
    awvalid = 1'b0;
    tests_run++;
    if (bvalid !== 1'b1 || bresp !== 3'b000) begin
      tests_failed++;
      $display("[TB] FAIL w_first_b: got bvalid=%b bresp=%0h want 1/0", bvalid, bresp);
    end
    bready = 1'b1;
    @(posedge clk); #1;
    bready = 1'b0;
    model_write(8'h04, 32'h1234, 4'hF);
    do_read(8'h04, d, r, ok);
    tests_run++;
    if (!ok || d !== 32'h1234 || r !== 3'b000) begin
      tests_failed++;
      $display("[TB] FAIL w_first_read: got ok=%b data=%0h resp=%0h want 1234/0", ok, d, r);
    end
  endtask

  // Out-of-range write and read at index 16 and 63.
  task automatic test_out_of_range();
    logic [31:0] d;
    logic [2:0]  r;
    bit ok;
    do_write(8'h40, $urandom, 4'hF, 0, 0, r, ok);
    tests_run++;
    if (!ok || r !== 3'b010) begin
      tests_failed++;
      $display("[TB] FAIL oor_write_resp: got ok=%b bresp=%0h want 2", ok, r);
    end
    for (int i = 0; i < DEPTH; i++) begin
      do_read(8'(i * 4), d, r, ok);
      tests_run++;
      if (!ok || d !== model_mem[i] || r !== 3'b000) begin
        tests_failed++;
        $display("[TB] FAIL oor_mem_word%0d: got data=%0h resp=%0h want %0h/0", i, d, r, model_mem[i]);
      end
    end
    do_read(8'h40, d, r, ok);
    tests_run++;
    if (!ok || d !== 32'h0 || r !== 3'b010) begin
      tests_failed++;
      $display("[TB] FAIL oor_read_40: got data=%0h resp=%0h want 0/2", d, r);
    end
    do_read(8'hFF, d, r, ok);
    tests_run++;
    if (!ok || d !== 32'h0 || r !== 3'b010) begin
      tests_failed++;
      $display("[TB] FAIL oor_read_ff: got data=%0h resp=%0h want 0/2", d, r);
    end
  endtask

  // Partial strobes and the all-zero strobe.
  task automatic test_wstrb();
    logic [31:0] d;
    logic [2:0]  r;
    logic [31:0] exp_val;
    bit ok;
`ifdef AXI_MEM_WSTRB_EN
    exp_val = 32'hAA22CC44;
`else
    exp_val = 32'h11223344;
`endif
    do_write(8'h08, 32'hAABBCCDD, 4'hF, 0, 0, r, ok);
    model_write(8'h08, 32'hAABBCCDD, 4'hF);
    do_write(8'h08, 32'h11223344, 4'b0101, 0, 1, r, ok);
    model_write(8'h08, 32'h11223344, 4'b0101);
    tests_run++;
    if (!ok || r !== 3'b000) begin
      tests_failed++;
      $display("[TB] FAIL wstrb_resp: got ok=%b bresp=%0h want 0", ok, r);
    end
    do_read(8'h08, d, r, ok);
    tests_run++;
    if (!ok || d !== exp_val) begin
      tests_failed++;
      $display("[TB] FAIL wstrb_read: got %0h want %0h", d, exp_val);
    end
    do_write(8'h09, 32'h5A5A5A5A, 4'h0, 1, 0, r, ok);
    tests_run++;
    if (!ok || r !== 3'b000) begin
      tests_failed++;
      $display("[TB] FAIL wstrb0_resp: got ok=%b bresp=%0h want 0", ok, r);
    end
    do_read(8'h0B, d, r, ok);
    tests_run++;
    if (!ok || d !== exp_val) begin
      tests_failed++;
      $display("[TB] FAIL wstrb0_read: got %0h want %0h", d, exp_val);
    end
  endtask

  // Concurrent write and read of one word held off by bready/rready.
  task automatic test_backpressure();
    logic [31:0] pre, newd, d;
    logic [2:0]  r;
    bit ok;
    pre  = model_read(8'h10);
    newd = ~pre;
    awaddr = 8'h10; wdata = newd; wstrb = 4'hF; awvalid = 1'b1; wvalid = 1'b1;
    araddr = 8'h10; arvalid = 1'b1; bready = 1'b0; rready = 1'b0;
    @(posedge clk); #1;
    awvalid = 1'b0; wvalid = 1'b0; arvalid = 1'b0;
    model_write(8'h10, newd, 4'hF);
    tests_run++;
    if ({bvalid, rvalid} !== 2'b11 || bresp !== 3'b000 || rresp !== 3'b000 || rdata !== pre) begin
      tests_failed++;
      $display("[TB] FAIL concurrent_first: got v=%b bresp=%0h rresp=%0h rdata=%0h want 11/0/0/%0h",
               {bvalid, rvalid}, bresp, rresp, rdata, pre);
    end
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      tests_run++;
      if ({bvalid, rvalid, arready} !== 3'b110 || bresp !== 3'b000 ||
          rresp !== 3'b000 || rdata !== pre) begin
        tests_failed++;
        $display("[TB] FAIL hold_cycle%0d: got v=%b bresp=%0h rresp=%0h rdata=%0h want 110/0/0/%0h",
                 i, {bvalid, rvalid, arready}, bresp, rresp, rdata, pre);
      end
    end
    bready = 1'b1; rready = 1'b1;
    @(posedge clk); #1;
    bready = 1'b0; rready = 1'b0;
    tests_run++;
    if ({bvalid, rvalid} !== 2'b00 || {awready, wready, arready} !== 3'b111) begin
      tests_failed++;
      $display("[TB] FAIL hold_release: got v=%b rdy=%b want 00/111",
               {bvalid, rvalid}, {awready, wready, arready});
    end
    do_read(8'h10, d, r, ok);
    tests_run++;
    if (!ok || d !== newd) begin
      tests_failed++;
      $display("[TB] FAIL concurrent_after: got %0h want %0h", d, newd);
    end
  endtask

  // Reset between the AW and W handshakes.
  task automatic test_reset_mid();
    logic [31:0] d;
    logic [2:0]  r;
    bit ok;
    awaddr = 8'h14; awvalid = 1'b1; wdata = 32'hDEADBEEF; wstrb = 4'hF; bready = 1'b1;
    @(posedge clk); #1;
    awvalid = 1'b0;
    tests_run++;
    if ({awready, wready} !== 2'b01) begin
      tests_failed++;
      $display("[TB] FAIL mid_aw_latched: got %b want 01", {awready, wready});
    end
    rst_n = 1'b0;
    #2;
    tests_run++;
    if ({awready, wready, arready, bvalid, rvalid} !== 5'b0) begin
      tests_failed++;
      $display("[TB] FAIL mid_async: got %b want 00000", {awready, wready, arready, bvalid, rvalid});
    end
    #2 rst_n = 1'b1;
    for (int i = 0; i < DEPTH; i++) model_mem[i] = '0;
    @(posedge clk); #1;
    tests_run++;
    if ({awready, wready, arready, bvalid} !== 4'b1110) begin
      tests_failed++;
      $display("[TB] FAIL mid_release: got %b want 1110", {awready, wready, arready, bvalid});
    end
    wvalid = 1'b1;
    @(posedge clk); #1;
    wvalid = 1'b0;
    repeat (3) begin
      @(posedge clk); #1;
      tests_run++;
      if (bvalid !== 1'b0) begin
        tests_failed++;
        $display("[TB] FAIL mid_no_resp: got bvalid=%b want 0", bvalid);
      end
    end
    awaddr = 8'h14; awvalid = 1'b1;
    @(posedge clk); #1;
    awvalid = 1'b0;
    tests_run++;
    if (bvalid !== 1'b1 || bresp !== 3'b000) begin
      tests_failed++;
      $display("[TB] FAIL mid_complete: got bvalid=%b bresp=%0h want 1/0", bvalid, bresp);
    end
    @(posedge clk); #1;
    bready = 1'b0;
    model_write(8'h14, 32'hDEADBEEF, 4'hF);
    do_read(8'h14, d, r, ok);
    tests_run++;
    if (!ok || d !== model_read(8'h14)) begin
      tests_failed++;
      $display("[TB] FAIL mid_read14: got %0h want %0h", d, model_read(8'h14));
    end
    do_read(8'h04, d, r, ok);
    tests_run++;
    if (!ok || d !== 32'h0) begin
      tests_failed++;
      $display("[TB] FAIL mid_cleared: got %0h want 0", d);
    end
  endtask

  // Random mix of writes and reads, including out-of-range addresses.
  task automatic test_random();
    logic [31:0] d, dat;
    logic [2:0]  r;
    logic [7:0]  a;
    logic [3:0]  s;
    bit ok;
    for (int n = 0; n < 40; n++) begin
      a = {6'($urandom_range(0, 11)), 2'($urandom)};
      if ($urandom_range(0, 1) == 1) begin
        dat = $urandom;
        s   = 4'($urandom);
        do_write(a, dat, s, $urandom_range(0, 3), $urandom_range(0, 3), r, ok);
        tests_run++;
        if (!ok || r !== model_resp(a)) begin
          tests_failed++;
          $display("[TB] FAIL rand_write a=%0h: got ok=%b bresp=%0h want %0h", a, ok, r, model_resp(a));
        end
        model_write(a, dat, s);
      end else begin
        do_read(a, d, r, ok);
        tests_run++;
        if (!ok || d !== model_read(a) || r !== model_resp(a)) begin
          tests_failed++;
          $display("[TB] FAIL rand_read a=%0h: got ok=%b data=%0h resp=%0h want %0h/%0h",
                   a, ok, d, r, model_read(a), model_resp(a));
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_same_cycle();
    test_w_before_aw();
    test_out_of_range();
    test_wstrb();
    test_backpressure();
    test_reset_mid();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
